// File: rtl/screen_update_pkg.sv
// Shared types and constants for the screen-update controller.
// State encoding, screen select codes, screen geometry and the cell request entry.
package screen_update_pkg;

    localparam int unsigned SCREEN_W     = 320;
    localparam int unsigned SCREEN_H     = 240;
    localparam int unsigned TOTAL_PIXELS = SCREEN_W * SCREEN_H;

    localparam logic [2:0] S_BLACK_SCREEN       = 3'd0;
    localparam logic [2:0] S_GAME_BOARD         = 3'd1;
    localparam logic [2:0] S_PLAYER1_WIN_SCREEN = 3'd2;
    localparam logic [2:0] S_PLAYER2_WIN_SCREEN = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FULL,
        S_CELL,
        S_DONE
    } state_e;

    // One queued cell draw: top-left corner of the cell.
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
    } cell_req_t;

endpackage

// File: rtl/cell_req_fifo.sv
// Small synchronous FIFO of cell draw requests ({x,y}, 17 bits per entry).
// Depth must be a power of two (>= 2); push when full and pop when empty are ignored.
module cell_req_fifo
    import screen_update_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  cell_req_t                data_i,
    input  logic                     pop_i,
    output cell_req_t                data_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    cell_req_t        mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = count_q[AW];          // count == Depth, Depth being a power of two
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Entry storage, no reset needed: occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/screen_update_controller.sv
// Screen-update sequencer: arbitrates full-screen redraws and cell draws, pulses
// START_DRAWING, drives screen_state, scans cell pixels and strobes the VGA plot.
// Optional feature macro CELL_FIFO_EN: buffer cell requests in a FIFO_DEPTH-entry FIFO
// instead of a single holding register.
module screen_update_controller
    import screen_update_pkg::*;
#(
    parameter int unsigned CELL_SIZE  = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLOCK,
    input  logic        RESETN,
    input  logic        scr_req,
    input  logic [2:0]  scr_state,
    output logic        scr_ack,
    input  logic        cell_valid,
    output logic        cell_ready,
    input  logic [8:0]  cell_base_x,
    input  logic [7:0]  cell_base_y,
    input  logic [16:0] screen_counter,
    output logic        START_DRAWING,
    output logic [2:0]  screen_state,
    output logic [8:0]  cell_x_out,
    output logic [7:0]  cell_y_out,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [16:0] LastPix = 17'(TOTAL_PIXELS);
    localparam logic [3:0]  DMax    = 4'(CELL_SIZE - 1);

    if (CELL_SIZE < 1 || CELL_SIZE > 16) begin : g_bad_cell_size
        $error("CELL_SIZE must be 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    state_e     state_q;
    logic       full_mode_q, drain_q;
    logic       scr_ack_q, start_q, done_q, cell_plot_q;
    logic [2:0] screen_state_q;
    logic [8:0] base_x_q, cell_x_q, next_x;
    logic [7:0] base_y_q, cell_y_q, next_y;
    logic [3:0] dx_q, dy_q, dx_next, dy_next;
    logic       last_dx, last_cell;
    logic       full_plot;

    cell_req_t  cell_in, head;
    logic       have_entry, cell_push, cell_pop;

    assign cell_in   = {cell_base_x, cell_base_y};
    assign cell_push = cell_valid & cell_ready;
    // scr_req has priority, so a stored cell is only taken when no redraw is requested.
    assign cell_pop  = (state_q == S_IDLE) & ~scr_req & have_entry;

`ifdef CELL_FIFO_EN
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full, fifo_empty;

    cell_req_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_cell_req_fifo (
        .clk_i   (CLOCK),
        .rst_ni  (RESETN),
        .push_i  (cell_push),
        .data_i  (cell_in),
        .pop_i   (cell_pop),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cell_ready = ~fifo_full;
    assign have_entry = (fifo_count != '0) & ~fifo_empty;
`else
    logic      held_q;
    cell_req_t held_data_q;

    // Single-entry holding register; push and pop never coincide since ready = ~held.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            held_q      <= 1'b0;
            held_data_q <= '0;
        end else if (cell_pop) begin
            held_q <= 1'b0;
        end else if (cell_push) begin
            held_q      <= 1'b1;
            held_data_q <= cell_in;
        end
    end

    assign cell_ready = ~held_q;
    assign have_entry = held_q;
    assign head       = held_data_q;
`endif

    // Next scan position (dx fastest) and its truncated pixel coordinates.
    always_comb begin
        last_dx   = (dx_q == DMax);
        last_cell = last_dx && (dy_q == DMax);
        dx_next   = last_dx ? 4'd0 : dx_q + 4'd1;
        dy_next   = last_dx ? dy_q + 4'd1 : dy_q;
        next_x    = base_x_q + 9'(dx_next);
        next_y    = base_y_q + 8'(dy_next);
    end

    // Main sequencer with registered strobes and coordinates.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q        <= S_IDLE;
            full_mode_q    <= 1'b0;
            drain_q        <= 1'b0;
            scr_ack_q      <= 1'b0;
            start_q        <= 1'b0;
            done_q         <= 1'b0;
            cell_plot_q    <= 1'b0;
            screen_state_q <= S_BLACK_SCREEN;
            base_x_q       <= '0;
            base_y_q       <= '0;
            cell_x_q       <= '0;
            cell_y_q       <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
        end else begin
            scr_ack_q   <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            cell_plot_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (scr_req) begin
                        screen_state_q <= scr_state;
                        full_mode_q    <= 1'b1;
                        scr_ack_q      <= 1'b1;
                        start_q        <= 1'b1;
                        state_q        <= S_START;
                    end else if (have_entry) begin
                        base_x_q       <= head.x;
                        base_y_q       <= head.y;
                        screen_state_q <= S_GAME_BOARD;
                        full_mode_q    <= 1'b0;
                        start_q        <= 1'b1;
                        state_q        <= S_START;
                    end
                end
                S_START: begin
                    if (full_mode_q) begin
                        state_q <= S_FULL;
                    end else begin
                        dx_q     <= '0;
                        dy_q     <= '0;
                        drain_q  <= 1'b0;
                        cell_x_q <= base_x_q;
                        cell_y_q <= base_y_q;
                        state_q  <= S_CELL;
                    end
                end
                S_FULL: begin
                    if (screen_counter == LastPix + 17'd1) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_CELL: begin
                    // The datapath registers the coordinates, so each plot trails its issue by one cycle.
                    if (drain_q) begin
                        drain_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cell_plot_q <= 1'b1;
                        if (last_cell) begin
                            drain_q <= 1'b1;
                        end else begin
                            dx_q     <= dx_next;
                            dy_q     <= dy_next;
                            cell_x_q <= next_x;
                            cell_y_q <= next_y;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Full-screen plot follows the datapath pixel counter directly.
    assign full_plot = (state_q == S_FULL) && (screen_counter != '0) &&
                       (screen_counter <= LastPix);

    assign scr_ack       = scr_ack_q;
    assign START_DRAWING = start_q;
    assign screen_state  = screen_state_q;
    assign cell_x_out    = cell_x_q;
    assign cell_y_out    = cell_y_q;
    assign plot          = full_plot | cell_plot_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_screen_update_controller.sv
// Bench for screen_update_controller: datapath counter model, scoreboard of expected
// pixels and update completions, directed scenarios for both storage modes.
module tb_screen_update_controller;

    localparam int CS  = 10;
    localparam int TOT = 76800;
`ifdef CELL_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        CLOCK = 1'b0;
    logic        RESETN;
    logic        scr_req, scr_ack, cell_valid, cell_ready;
    logic [2:0]  scr_state, screen_state;
    logic [8:0]  cell_base_x, cell_x_out;
    logic [7:0]  cell_base_y, cell_y_out;
    logic [16:0] screen_counter;
    logic        START_DRAWING, plot, busy, done;

    screen_update_controller #(
        .CELL_SIZE  (CS),
        .FIFO_DEPTH (4)
    ) dut (
        .CLOCK          (CLOCK),
        .RESETN         (RESETN),
        .scr_req        (scr_req),
        .scr_state      (scr_state),
        .scr_ack        (scr_ack),
        .cell_valid     (cell_valid),
        .cell_ready     (cell_ready),
        .cell_base_x    (cell_base_x),
        .cell_base_y    (cell_base_y),
        .screen_counter (screen_counter),
        .START_DRAWING  (START_DRAWING),
        .screen_state   (screen_state),
        .cell_x_out     (cell_x_out),
        .cell_y_out     (cell_y_out),
        .plot           (plot),
        .busy           (busy),
        .done           (done)
    );

    always #5 CLOCK = ~CLOCK;

    // Datapath model: counter restarts at 1 on START_DRAWING, runs to TOT+1 and holds.
    // skip_from/skip_to let later scenarios jump over most of the frame.
    int          skip_from = 0;
    int          skip_to   = 0;
    logic [16:0] cnt;
    always @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN)                     cnt <= '0;
        else if (START_DRAWING)          cnt <= 17'd1;
        else if (cnt != 0 && cnt <= TOT) cnt <= (int'(cnt) == skip_from) ? 17'(skip_to) : cnt + 1;
    end
    assign screen_counter = cnt;

    // Datapath coordinate registers.
    logic [8:0] dp_x;
    logic [7:0] dp_y;
    always @(posedge CLOCK) begin
        dp_x <= cell_x_out;
        dp_y <= cell_y_out;
    end

    logic [16:0] pix_q  [$];
    logic [2:0]  done_q [$];
    int n_tests = 0, n_fail = 0;
    int cell_plots = 0, full_plots = 0, starts = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every plot and every done pulse is matched against expectations.
    always @(negedge CLOCK) begin
        if (RESETN) begin
            if (START_DRAWING) starts++;
            if (plot) begin
                if (screen_state == 3'd1) begin
                    cell_plots++;
                    if (pix_q.size() == 0) check_eq("pix_underflow", 1, 0);
                    else check_eq("pix_xy", {15'd0, dp_x, dp_y}, {15'd0, pix_q.pop_front()});
                end else begin
                    full_plots++;
                end
            end
            if (done) begin
                if (done_q.size() == 0) check_eq("done_underflow", 1, 0);
                else check_eq("done_screen", {29'd0, screen_state}, {29'd0, done_q.pop_front()});
            end
        end
    end

    task automatic exp_cell(input logic [8:0] x, input logic [7:0] y);
        for (int dy = 0; dy < CS; dy++) begin
            for (int dx = 0; dx < CS; dx++) begin
                logic [8:0] px;
                logic [7:0] py;
                px = x + 9'(dx);
                py = y + 8'(dy);
                pix_q.push_back({px, py});
            end
        end
        done_q.push_back(3'd1);
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic push_cell(input logic [8:0] x, input logic [7:0] y, input logic rdy_now,
                             input string tag);
        int w = 0;
        cell_valid  = 1'b1;
        cell_base_x = x;
        cell_base_y = y;
        check_eq(tag, {31'd0, cell_ready}, {31'd0, rdy_now});
        while (!cell_ready && w < 2000) begin
            @(negedge CLOCK);
            w++;
        end
        if (!cell_ready) begin
            check_eq({tag, "_timeout"}, 1, 0);
        end else begin
            @(posedge CLOCK);
            exp_cell(x, y);
            @(negedge CLOCK);
        end
        cell_valid = 1'b0;
    endtask

    task automatic req_screen(input logic [2:0] s, input string tag);
        int w = 0;
        scr_req   = 1'b1;
        scr_state = s;
        done_q.push_back(s);
        do begin
            @(negedge CLOCK);
            w++;
        end while (!scr_ack && w < 100);
        check_eq(tag, {31'd0, scr_ack}, 1);
        scr_req = 1'b0;
    endtask

    task automatic wait_quiet(input int max, input string tag);
        int w = 0;
        while ((busy || done_q.size() != 0) && w < max) begin
            @(negedge CLOCK);
            w++;
        end
        check_eq(tag, {31'd0, (busy || done_q.size() != 0)}, 0);
        check_eq({tag, "_pix_left"}, pix_q.size(), 0);
    endtask

    initial begin
        int w, mism, fp0, st0, cp0, busy_seen;
        RESETN = 1'b0; scr_req = 1'b0; scr_state = 3'd0;
        cell_valid = 1'b0; cell_base_x = '0; cell_base_y = '0;
        repeat (3) @(negedge CLOCK);
        check_eq("rst_outs", {24'd0, scr_ack, START_DRAWING, plot, busy, done, screen_state}, 0);
        check_eq("rst_xy", {15'd0, cell_x_out, cell_y_out}, 0);
        check_eq("rst_ready", {31'd0, cell_ready}, 1);
        RESETN = 1'b1;

        // 1: full redraw of the player-1 win screen with exact plot count.
        @(negedge CLOCK);
        fp0 = full_plots; st0 = starts; mism = 0;
        scr_req = 1'b1; scr_state = 3'd2; done_q.push_back(3'd2);
        @(negedge CLOCK);
        check_eq("t1_ack", {31'd0, scr_ack}, 1);
        check_eq("t1_start", {31'd0, START_DRAWING}, 1);
        check_eq("t1_state", {29'd0, screen_state}, 2);
        scr_req = 1'b0;
        w = 0;
        while (!done && w < 80000) begin
            if (plot !== ((cnt >= 1) && (cnt <= TOT))) mism++;
            @(negedge CLOCK);
            w++;
        end
        check_eq("t1_done_seen", {31'd0, done}, 1);
        check_eq("t1_plot_rule", mism, 0);
        check_eq("t1_plots", full_plots - fp0, TOT);
        check_eq("t1_starts", starts - st0, 1);
        @(negedge CLOCK);
        check_eq("t1_done_one", {30'd0, done, busy}, 0);

        skip_from = 5; skip_to = TOT - 40;

        // 2: single cell draw.
        cp0 = cell_plots;
        push_cell(9'd100, 8'd50, 1'b1, "t2_ready");
        wait_quiet(300, "t2_quiet");
        check_eq("t2_plots", cell_plots - cp0, 100);

        // 3: redraw and cell requested in the same idle cycle.
        cp0 = cell_plots;
        scr_req = 1'b1; scr_state = 3'd3;
        cell_valid = 1'b1; cell_base_x = 9'd200; cell_base_y = 8'd100;
        check_eq("t3_ready", {31'd0, cell_ready}, 1);
        done_q.push_back(3'd3);
        @(posedge CLOCK);
        exp_cell(9'd200, 8'd100);
        @(negedge CLOCK);
        check_eq("t3_ack", {31'd0, scr_ack}, 1);
        check_eq("t3_ready_after", {31'd0, cell_ready}, (CAP > 1) ? 1 : 0);
        scr_req = 1'b0; cell_valid = 1'b0;
        wait_quiet(1000, "t3_quiet");
        check_eq("t3_plots", cell_plots - cp0, 100);

        // 4: more cells pushed during a redraw than the storage holds.
        cp0 = cell_plots;
        req_screen(3'd0, "t4_ack");
        for (int i = 0; i <= CAP; i++)
            push_cell(9'(10 + 20 * i), 8'(20 + 15 * i), (i < CAP), "t4_ready");
        wait_quiet(3000, "t4_quiet");
        check_eq("t4_plots", cell_plots - cp0, 100 * (CAP + 1));

        // 6: cell near the right/bottom edge, no clamping.
        cp0 = cell_plots;
        push_cell(9'd315, 8'd235, 1'b1, "t6_ready");
        wait_quiet(300, "t6_quiet");
        check_eq("t6_plots", cell_plots - cp0, 100);

        // 5: reset in the middle of a redraw with a cell queued.
        skip_to = 39990;
        req_screen(3'd2, "t5_ack");
        push_cell(9'd7, 8'd7, 1'b1, "t5_ready");
        w = 0;
        while (cnt != 17'd40000 && w < 200) begin
            @(negedge CLOCK);
            w++;
        end
        check_eq("t5_reach", {15'd0, cnt}, 40000);
        RESETN = 1'b0;
        #1;
        check_eq("t5_outs", {24'd0, scr_ack, START_DRAWING, plot, busy, done, screen_state}, 0);
        check_eq("t5_xy", {15'd0, cell_x_out, cell_y_out}, 0);
        check_eq("t5_empty", {31'd0, cell_ready}, 1);
        pix_q.delete();
        done_q.delete();
        @(negedge CLOCK);
        RESETN = 1'b1;
        busy_seen = 0;
        repeat (50) begin
            @(negedge CLOCK);
            if (busy) busy_seen++;
        end
        check_eq("t5_no_resume", busy_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
